spi_flash_rd_seq: RTL and testbench
===================================

# spi_flash_rd_seq

Command sequencer for reading serial NOR flash through the SPI byte engine's transmit/receive byte streams. One request, consisting of a 24-bit address and a byte count, becomes one chip-select window on the engine:
- opcode `CMD_READ`,
- three address bytes, MSB first,
- `len+1` dummy `0x00` bytes, whose received bytes are returned as read data.

It sits between the boot/XIP fetch logic and the SPI engine, owns chip-select for the flash device, and drops received bytes that belong to the command/address phase.

## Interface
Parameters:
- `LEN_W`, default 8: width of the length field; maximum transfer is 2^LEN_W bytes.
- `CMD_READ`, default 8'h03: opcode sent as the first byte.
- `CS_HOLD`, default 2: number of hclk cycles nss_o stays high after a window before done_o; must be ≥1.

Ports:
- `hclk`: in, 1. Single clock.
- `hreset`: in, 1. Synchronous, active-high reset.
- `req_i`: in, 1. Read request; accepted in the cycle where `req_i && req_ready_o`.
- `req_addr_i`: in, 24. Flash byte address; sampled on accept.
- `req_len_i`: in, LEN_W. Byte count minus 1; sampled on accept.
- `req_ready_o`: out, 1. High only in IDLE.
- `abort_i`: in, 1. Terminates the current window.
- `rdata_o`: out, 8. Read data byte.
- `rvalid_o`: out, 1. One-cycle strobe per data byte. No backpressure.
- `done_o`: out, 1. One-cycle pulse at the end of a window.
- `aborted_o`: out, 1. Qualifies done_o; high if the window was aborted.
- `busy_o`: out, 1. High whenever the FSM is not in IDLE.
- `tx_valid_o`: out, 1. Byte offered to the engine.
- `tx_data_o`: out, 8. Byte value offered to the engine.
- `tx_ready_i`: in, 1. Engine accepts the byte when `tx_valid_o && tx_ready_i`.
- `rx_valid_i`: in, 1. One received byte per strobe, in the same order as transmitted bytes.
- `rx_data_i`: in, 8. Received byte value.
- `nss_o`: out, 1. Flash chip-select, active low.

## Operation
- States: IDLE, CMD, ADDR, DATA, DRAIN, HOLD.
- **IDLE**
  - On accept, latch addr and len, clear tx_cnt and rx_cnt, go to CMD.
  - rx_valid_i is ignored in IDLE.
- **CMD**
  - nss_o=0, tx_valid_o=1, tx_data_o=CMD_READ.
  - On handshake, go to ADDR.
- **ADDR**
  - Sends addr[23:16], then addr[15:8], then addr[7:0], one byte per handshake.
  - After the third handshake, go to DATA.
- **DATA**
  - Sends 0x00 until the total number of tx handshakes equals len+5, then go to DRAIN.
- **DRAIN**
  - tx_valid_o=0, nss_o stays 0.
  - Wait until rx_cnt reaches len+5, then go to HOLD.
- **HOLD**
  - nss_o=1 for CS_HOLD cycles.
  - In the last cycle, assert done_o, then return to IDLE.
- **Receive path**, in CMD through DRAIN
  - Each rx_valid_i increments rx_cnt.
  - rx bytes with index 0–3 are discarded.
  - rx bytes with index ≥4 produce rdata_o and rvalid_o.
- **Counters**
  - tx_cnt and rx_cnt are LEN_W+3 bits wide; neither wraps within a window.
  - req_len_i = 2^LEN_W−1 yields 2^LEN_W data bytes.
- **Simultaneous events**
  - A tx handshake and rx_valid_i in the same cycle are counted independently.
  - A tx handshake in the same cycle as abort_i is counted, but no further bytes are offered.
- **Abort**
  - abort_i in CMD, ADDR, DATA or DRAIN goes to HOLD next cycle; tx_valid_o drops in that cycle.
  - rx bytes arriving in HOLD are discarded.
  - done_o and aborted_o pulse together at the end of HOLD.
  - abort_i in IDLE or HOLD is ignored.
- **Reset**
  - hreset mid-window returns to IDLE immediately.
  - The engine must be reset together with this block.

## Timing
- Reset values: nss_o=1, tx_valid_o=0, tx_data_o=0, rvalid_o=0, rdata_o=0, done_o=0, aborted_o=0, busy_o=0, req_ready_o=1.
- Accept at cycle T: CMD state and tx_valid_o=1 at T+1.
- tx_valid_o and tx_data_o hold stable until the handshake.
- The next byte is offered in the cycle after a handshake, so there is one bubble per byte.
- rvalid_o and rdata_o are registered: they appear 1 cycle after the corresponding rx_valid_i.
- Last rx byte at cycle R: nss_o=1 at R+1, done_o at R+CS_HOLD, req_ready_o=1 at R+CS_HOLD+1.
- All outputs are registered except req_ready_o and busy_o, which decode state.

## Structure
- `spi_pkg` holds:
  - the state encoding for IDLE, CMD, ADDR, DATA, DRAIN, HOLD;
  - the CMD_READ default;
  - a shared localparam for the 4-byte command/address header length.
- No sub-module: the FSM, the two counters and the address shift register stay inline.

## Test plan
- addr=0x012345, len=3, engine always ready, rx echoes 0xA0+index → tx 03,01,23,45,00,00,00,00. Then rvalid_o ×4 with A4,A5,A6,A7. Then done_o=1, aborted_o=0, nss_o low for the whole window.
- tx_ready_i toggled 1-in-3 with the same request → identical byte sequence, tx_data_o stable while stalled, no duplicate bytes.
- len=0xFF → 260 tx bytes, 256 rvalid_o strobes, counters do not wrap, single done_o.
- abort_i during the 2nd data byte → nss_o=1 next cycle, no further rvalid_o, done_o and aborted_o pulse after CS_HOLD cycles, next request starts cleanly.
- hreset asserted in ADDR → all outputs at reset values next cycle, req_ready_o=1.
- req_i held continuously → back-to-back windows separated by CS_HOLD cycles of nss_o=1, and req_ready_o=0 throughout each window.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI flash read command sequencer.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_HOLD  = 3'd5
    } state_e;

    localparam logic [7:0] CMD_READ_DEF = 8'h03;

    // Opcode plus three address bytes precede the first data byte.
    localparam int unsigned HDR_LEN = 4;

endpackage

// File: rtl/spi_flash_rd_seq.sv
// Serial NOR read sequencer: turns one (addr, len) request into a single
// chip-select window of opcode, address and dummy bytes on the SPI byte engine.
module spi_flash_rd_seq
    import spi_pkg::*;
#(
    parameter int unsigned LEN_W    = 8,
    parameter logic [7:0]  CMD_READ = CMD_READ_DEF,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic             hclk,
    input  logic             hreset,
    input  logic             req_i,
    input  logic [23:0]      req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    output logic             req_ready_o,
    input  logic             abort_i,
    output logic [7:0]       rdata_o,
    output logic             rvalid_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic             busy_o,
    output logic             tx_valid_o,
    output logic [7:0]       tx_data_o,
    input  logic             tx_ready_i,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    output logic             nss_o
);

    localparam int unsigned CNT_W  = LEN_W + 3;
    localparam int unsigned HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0]  HDR_CNT   = CNT_W'(HDR_LEN);

    state_e            state_q, state_d;
    logic [23:0]       addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              abort_q, abort_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              nss_q, nss_d;
    logic              rvalid_q, rvalid_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic              active;
    logic              tx_hs;
    logic [CNT_W-1:0]  total;
    logic [CNT_W-1:0]  tx_cnt_inc;

    assign active     = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                        (state_q == ST_DATA) || (state_q == ST_DRAIN);
    assign tx_hs      = tx_valid_q && tx_ready_i;
    assign total      = CNT_W'(len_q) + CNT_W'(HDR_LEN + 1);
    assign tx_cnt_inc = tx_cnt_q + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        hold_cnt_d = hold_cnt_q;
        abort_d    = abort_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        nss_d      = nss_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    addr_d     = req_addr_i;
                    len_d      = req_len_i;
                    tx_cnt_d   = '0;
                    rx_cnt_d   = '0;
                    abort_d    = 1'b0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = CMD_READ;
                    nss_d      = 1'b0;
                    state_d    = ST_CMD;
                end
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
                if (tx_hs) begin
                    // Drop valid for one cycle after each accepted byte.
                    tx_valid_d = 1'b0;
                    tx_cnt_d   = tx_cnt_inc;
                    if (state_q == ST_CMD) begin
                        state_d = ST_ADDR;
                    end else if (state_q == ST_ADDR) begin
                        addr_d = {addr_q[15:0], 8'h00};
                        if (tx_cnt_inc == HDR_CNT) begin
                            state_d = ST_DATA;
                        end
                    end else if (tx_cnt_inc == total) begin
                        state_d = ST_DRAIN;
                    end
                end else if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = (state_q == ST_ADDR) ? addr_q[23:16] : 8'h00;
                end
            end
            ST_DRAIN: begin
                tx_valid_d = 1'b0;
            end
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else if ((hold_cnt_q + HOLD_W'(1)) == HOLD_LAST) begin
                    done_d    = 1'b1;
                    aborted_d = abort_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Receive path: header echoes are counted but not forwarded.
        if (active) begin
            if (rx_valid_i) begin
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
                if (rx_cnt_q >= HDR_CNT) begin
                    rvalid_d = 1'b1;
                    rdata_d  = rx_data_i;
                end
            end
            if (abort_i || ((tx_cnt_d == total) && (rx_cnt_d == total))) begin
                state_d    = ST_HOLD;
                tx_valid_d = 1'b0;
                nss_d      = 1'b1;
                hold_cnt_d = '0;
                abort_d    = abort_i;
                if (HOLD_LAST == '0) begin
                    done_d    = 1'b1;
                    aborted_d = abort_i;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            hold_cnt_q <= '0;
            abort_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            nss_q      <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= 8'h00;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            abort_q    <= abort_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            nss_q      <= nss_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_data_q;
    assign nss_o       = nss_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Self-checking bench for spi_flash_rd_seq with a byte-level engine model.
module tb_spi_flash_rd_seq;

    localparam int unsigned LEN_W   = 8;
    localparam int          CS_HOLD = 2;
    localparam logic [7:0]  CMD     = 8'h03;

    logic             hclk;
    logic             hreset;
    logic             req_i;
    logic [23:0]      req_addr_i;
    logic [LEN_W-1:0] req_len_i;
    logic             req_ready_o;
    logic             abort_i;
    logic [7:0]       rdata_o;
    logic             rvalid_o;
    logic             done_o;
    logic             aborted_o;
    logic             busy_o;
    logic             tx_valid_o;
    logic [7:0]       tx_data_o;
    logic             tx_ready_i;
    logic             rx_valid_i;
    logic [7:0]       rx_data_i;
    logic             nss_o;

    spi_flash_rd_seq #(.LEN_W(LEN_W), .CMD_READ(CMD), .CS_HOLD(CS_HOLD)) dut (
        .hclk(hclk), .hreset(hreset),
        .req_i(req_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .req_ready_o(req_ready_o), .abort_i(abort_i),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .done_o(done_o),
        .aborted_o(aborted_o), .busy_o(busy_o),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .nss_o(nss_o)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_errors = 0;

    // Engine model and observation logs
    int         cyc = 0;
    int         rx_due[$];
    int         rx_arr[$];
    logic [7:0] tx_log[$];
    logic [7:0] rd_log[$];
    int         eng_idx, last_due, eng_lat, ready_mode;
    int         done_cnt, done_cyc, last_rx_cyc, nss_rise_cyc, acc_cnt;
    int         stall_viol, nss_viol, ready_viol;
    int         hi_run, min_gap;
    logic       aborted_seen, prev_stall, prev_nss, seen_low, chk_rx_nss;
    logic [7:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_tx(input logic [23:0] a, input int k);
        if (k == 0) return CMD;
        if (k == 1) return a[23:16];
        if (k == 2) return a[15:8];
        if (k == 3) return a[7:0];
        return 8'h00;
    endfunction

    task automatic clear_logs();
        rx_due.delete(); rx_arr.delete(); tx_log.delete(); rd_log.delete();
        eng_idx = 0; last_due = 0; done_cnt = 0; done_cyc = -1; last_rx_cyc = -1;
        nss_rise_cyc = -1; acc_cnt = 0; stall_viol = 0; nss_viol = 0; ready_viol = 0;
        prev_stall = 1'b0; hi_run = 0; min_gap = 1000; seen_low = 1'b0;
        aborted_seen = 1'b0; prev_nss = nss_o;
    endtask

    // One clock cycle: drive engine inputs, observe mid-cycle, advance.
    task automatic cycle();
        int d;
        if (rx_due.size() > 0 && rx_due[0] == cyc) begin
            void'(rx_due.pop_front());
            rx_valid_i = 1'b1;
            rx_data_i  = 8'(8'hA0 + eng_idx);
            rx_arr.push_back(cyc);
            eng_idx++;
        end else begin
            rx_valid_i = 1'b0;
            rx_data_i  = 8'($urandom);
        end
        tx_ready_i = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        #4;
        if (tx_valid_o && tx_ready_i) begin
            tx_log.push_back(tx_data_o);
            d = cyc + ((eng_lat > 0) ? eng_lat : int'($urandom_range(1, 3)));
            if (d <= last_due) d = last_due + 1;
            rx_due.push_back(d);
            last_due = d;
        end
        if (prev_stall && !(tx_valid_o && tx_data_o == prev_data)) stall_viol++;
        prev_stall = tx_valid_o && !tx_ready_i;
        prev_data  = tx_data_o;
        if (tx_valid_o && nss_o) nss_viol++;
        if (chk_rx_nss && rx_valid_i && nss_o) nss_viol++;
        if ((!nss_o && req_ready_o) || (busy_o == req_ready_o)) ready_viol++;
        if (aborted_o && !done_o) ready_viol++;
        if (req_i && req_ready_o) acc_cnt++;
        if (rvalid_o) rd_log.push_back(rdata_o);
        if (rx_valid_i) last_rx_cyc = cyc;
        if (done_o) begin done_cnt++; done_cyc = cyc; aborted_seen = aborted_o; end
        if (nss_o && !prev_nss) nss_rise_cyc = cyc;
        if (nss_o) hi_run++;
        else begin
            if (prev_nss && seen_low && hi_run < min_gap) min_gap = hi_run;
            hi_run = 0; seen_low = 1'b1;
        end
        prev_nss = nss_o;
        @(posedge hclk);
        #1;
        cyc++;
    endtask

    // Issue one request and check the whole window against the byte-level model.
    task automatic run_req(input logic [23:0] addr, input int len, input int rmode,
                           input int lat, input int abort_at);
        int t, abort_cyc, n_tx;
        logic [7:0] exp_rd[$];
        clear_logs();
        ready_mode = rmode; eng_lat = lat; chk_rx_nss = (abort_at < 0); abort_cyc = -1;
        req_addr_i = addr; req_len_i = LEN_W'(len); req_i = 1'b1;
        t = 0;
        while (!req_ready_o && t < 100) begin cycle(); t++; end
        cycle();
        req_i = 1'b0; req_addr_i = 24'($urandom); req_len_i = LEN_W'($urandom);
        chk("cmd_valid", 32'(tx_valid_o), 1);
        chk("cmd_data", 32'(tx_data_o), 32'(CMD));
        chk("cmd_nss", 32'(nss_o), 0);
        chk("cmd_ready", 32'(req_ready_o), 0);
        t = 0;
        while (done_cnt == 0 && t < 5000) begin
            if (abort_at >= 0 && abort_cyc < 0 && tx_valid_o && tx_log.size() == abort_at) begin
                abort_i = 1'b1; abort_cyc = cyc;
                cycle();
                abort_i = 1'b0;
                chk("abort_txv", 32'(tx_valid_o), 0);
                chk("abort_nss", 32'(nss_o), 1);
            end else begin
                cycle();
            end
            t++;
        end
        chk("done_seen", 32'(done_cnt > 0), 1);
        chk("ready_after_done", 32'(req_ready_o), 1);
        if (abort_at >= 0) begin
            n_tx = abort_at + 1;
            chk("abort_done_time", 32'(done_cyc - abort_cyc), 32'(CS_HOLD));
            chk("abort_flag", 32'(aborted_seen), 1);
        end else begin
            n_tx = len + 5;
            chk("nss_rise_time", 32'(nss_rise_cyc - last_rx_cyc), 1);
            chk("done_time", 32'(done_cyc - last_rx_cyc), 32'(CS_HOLD));
            chk("abort_flag", 32'(aborted_seen), 0);
        end
        chk("tx_count", 32'(tx_log.size()), 32'(n_tx));
        for (int k = 0; k < tx_log.size() && k < n_tx; k++)
            chk($sformatf("tx_byte%0d", k), 32'(tx_log[k]), 32'(exp_tx(addr, k)));
        repeat (3) cycle();
        chk("done_count", 32'(done_cnt), 1);
        for (int i = 4; i < rx_arr.size(); i++)
            if (abort_cyc < 0 || rx_arr[i] <= abort_cyc) exp_rd.push_back(8'(8'hA0 + i));
        chk("rd_count", 32'(rd_log.size()), 32'(exp_rd.size()));
        for (int k = 0; k < rd_log.size() && k < exp_rd.size(); k++)
            chk($sformatf("rd_byte%0d", k), 32'(rd_log[k]), 32'(exp_rd[k]));
        chk("stall_stable", 32'(stall_viol), 0);
        chk("nss_window", 32'(nss_viol), 0);
        chk("ready_busy", 32'(ready_viol), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_nss"}, 32'(nss_o), 1);
        chk({tag, "_txv"}, 32'(tx_valid_o), 0);
        chk({tag, "_txd"}, 32'(tx_data_o), 0);
        chk({tag, "_rvalid"}, 32'(rvalid_o), 0);
        chk({tag, "_rdata"}, 32'(rdata_o), 0);
        chk({tag, "_done"}, 32'(done_o), 0);
        chk({tag, "_aborted"}, 32'(aborted_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_ready"}, 32'(req_ready_o), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        hreset = 1'b1; req_i = 1'b0; req_addr_i = '0; req_len_i = '0; abort_i = 1'b0;
        tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0;
        ready_mode = 0; eng_lat = 2; chk_rx_nss = 1'b1;
        @(posedge hclk); #1;
        clear_logs();
        repeat (2) cycle();
        chk_reset_vals("rst");
        hreset = 1'b0;
        cycle();

        run_req(24'h012345, 3, 0, 2, -1);
        run_req(24'h012345, 3, 1, 2, -1);
        run_req(24'($urandom), 255, 0, 0, -1);
        run_req(24'h00ABCD, 6, 0, 2, 5);
        run_req(24'($urandom), int'($urandom_range(0, 7)), 1, 0, -1);

        // Reset in the middle of the address phase.
        clear_logs();
        ready_mode = 0; eng_lat = 2;
        req_addr_i = 24'h5A5A5A; req_len_i = 8'd4; req_i = 1'b1;
        cycle();
        req_i = 1'b0;
        t = 0;
        while (tx_log.size() < 2 && t < 100) begin cycle(); t++; end
        chk("reached_addr", 32'(tx_log.size()), 2);
        hreset = 1'b1;
        cycle();
        hreset = 1'b0;
        chk_reset_vals("midrst");
        rx_due.delete();
        cycle();
        run_req(24'($urandom), int'($urandom_range(0, 12)), 1, 0, -1);

        // Back-to-back windows with req_i held.
        clear_logs();
        ready_mode = 0; eng_lat = 0; chk_rx_nss = 1'b1;
        req_addr_i = 24'h102030; req_len_i = 8'd1; req_i = 1'b1;
        t = 0;
        while (done_cnt < 3 && t < 2000) begin cycle(); t++; end
        req_i = 1'b0;
        repeat (4) cycle();
        chk("b2b_windows", 32'(acc_cnt), 3);
        chk("b2b_done", 32'(done_cnt), 3);
        chk("b2b_tx", 32'(tx_log.size()), 18);
        chk("b2b_rd", 32'(rd_log.size()), 6);
        chk("b2b_gap_ok", 32'(min_gap >= CS_HOLD && min_gap < 1000), 1);
        chk("b2b_ready", 32'(ready_viol), 0);
        chk("b2b_nss", 32'(nss_viol), 0);

        for (int r = 0; r < 6; r++)
            run_req(24'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 1)), 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
